core_ex_muldiv: RTL and testbench



---
 rtl/core_ex_muldiv.sv | 208 ++++++++++++++++++++
 tb/tb_core_ex_muldiv.sv | 136 +++++++++++++
 2 files changed

// File: rtl/core_ex_muldiv.sv
// core_ex_muldiv: iterative RISC-V M-extension unit (RV64 incl. W forms) in EX.
// One operation takes C+2 cycles in EX (C = 64, or 32 for W ops). The IDLE cycle
// latches operands, CALC runs one shift-add / restoring-divide step per cycle,
// and DONE presents the registered result for exactly one cycle.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   valid_i         EX instruction is an M-extension op
//   flush_i         kill in-flight op, forces stall_o low
//   funct3_i        M-extension operation select
//   word_i          OP-32 (W) variant
//   rs1_data_i      operand A
//   rs2_data_i      operand B
//   stall_o         hold front of pipeline while the op is in progress
//   busy_o          unit is not idle
//   result_valid_o  result_o valid (DONE)
//   result_o        registered result
module core_ex_muldiv #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic [2:0]      funct3_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;      // mul: product; div: {remainder, quotient/dividend}
    logic [2*XLEN-1:0]   mcand_q, mcand_d;  // mul: left-shifting multiplicand
    logic [XLEN-1:0]     opb_q, opb_d;      // mul: right-shifting multiplier; div: divisor
    logic [XLEN-1:0]     result_q, result_d;
    logic                is_div_q, is_div_d;
    logic                is_rem_q, is_rem_d;
    logic                is_high_q, is_high_d;
    logic                word_q, word_d;
    logic                neg_q, neg_d;
    logic                div_zero_q, div_zero_d;

    logic                start;
    logic                signed_a, signed_b, sa, sb;
    logic [XLEN-1:0]     a_ext, b_ext, a_mag, b_mag;

    logic [2*XLEN-1:0]   acc_it, mcand_it, prod;
    logic [XLEN-1:0]     opb_it, q_in, div_mag, div_res, sel;
    logic [XLEN:0]       shifted;
    logic                no_borrow;
    logic [XLEN-1:0]     res_fmt;

    assign start = valid_i && !flush_i;

    // Operand preparation: extension, sign capture and magnitudes
    always_comb begin
        signed_a = !(funct3_i == 3'b011 || funct3_i == 3'b101 || funct3_i == 3'b111);
        signed_b = (funct3_i == 3'b000 || funct3_i == 3'b001 ||
                    funct3_i == 3'b100 || funct3_i == 3'b110);
        if (word_i) begin
            a_ext = signed_a ? {{(XLEN-32){rs1_data_i[31]}}, rs1_data_i[31:0]}
                             : {{(XLEN-32){1'b0}}, rs1_data_i[31:0]};
            b_ext = signed_b ? {{(XLEN-32){rs2_data_i[31]}}, rs2_data_i[31:0]}
                             : {{(XLEN-32){1'b0}}, rs2_data_i[31:0]};
        end else begin
            a_ext = rs1_data_i;
            b_ext = rs2_data_i;
        end
        sa    = signed_a && a_ext[XLEN-1];
        sb    = signed_b && b_ext[XLEN-1];
        a_mag = sa ? -a_ext : a_ext;
        b_mag = sb ? -b_ext : b_ext;
    end

    // One iteration step plus final result formatting
    always_comb begin
        acc_it    = acc_q;
        mcand_it  = mcand_q;
        opb_it    = opb_q;
        shifted   = '0;
        no_borrow = 1'b0;
        q_in      = acc_q[XLEN-1:0];
        if (is_div_q) begin
            shifted   = {acc_q[2*XLEN-1:XLEN], q_in[XLEN-1]};
            no_borrow = (shifted >= {1'b0, opb_q});
            acc_it[2*XLEN-1:XLEN] = no_borrow ? (shifted[XLEN-1:0] - opb_q) : shifted[XLEN-1:0];
            acc_it[XLEN-1:0]      = {q_in[XLEN-2:0], no_borrow};
        end else begin
            acc_it   = acc_q + (opb_q[0] ? mcand_q : '0);
            mcand_it = mcand_q << 1;
            opb_it   = opb_q >> 1;
        end

        prod    = neg_q ? -acc_it : acc_it;
        div_mag = is_rem_q ? acc_it[2*XLEN-1:XLEN] : acc_it[XLEN-1:0];
        div_res = neg_q ? -div_mag : div_mag;
        // Zero divisor: remainder falls out of the algorithm as the dividend,
        // but the quotient must be forced to all ones regardless of sign.
        if (div_zero_q && !is_rem_q)
            div_res = '1;
        if (is_div_q)
            sel = div_res;
        else
            sel = is_high_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        res_fmt = word_q ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            opb_q      <= '0;
            result_q   <= '0;
            is_div_q   <= 1'b0;
            is_rem_q   <= 1'b0;
            is_high_q  <= 1'b0;
            word_q     <= 1'b0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            opb_q      <= opb_d;
            result_q   <= result_d;
            is_div_q   <= is_div_d;
            is_rem_q   <= is_rem_d;
            is_high_q  <= is_high_d;
            word_q     <= word_d;
            neg_q      <= neg_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        opb_d      = opb_q;
        result_d   = result_q;
        is_div_d   = is_div_q;
        is_rem_d   = is_rem_q;
        is_high_d  = is_high_q;
        word_d     = word_q;
        neg_d      = neg_q;
        div_zero_d = div_zero_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = CALC;
                    cnt_d      = word_i ? CW'(31) : CW'(XLEN-1);
                    is_div_d   = funct3_i[2];
                    is_rem_d   = funct3_i[2] && funct3_i[1];
                    // Illegal W mul-high encodings run as MULW
                    is_high_d  = !word_i && !funct3_i[2] && (funct3_i[1:0] != 2'b00);
                    word_d     = word_i;
                    neg_d      = (funct3_i[2] && funct3_i[1]) ? sa : (sa ^ sb);
                    div_zero_d = (b_ext == '0);
                    opb_d      = b_mag;
                    mcand_d    = {{XLEN{1'b0}}, a_mag};
                    if (funct3_i[2])
                        acc_d = {{XLEN{1'b0}}, word_i ? {a_mag[31:0], 32'b0} : a_mag};
                    else
                        acc_d = '0;
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d   = acc_it;
                    mcand_d = mcand_it;
                    opb_d   = opb_it;
                    cnt_d   = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d  = DONE;
                        result_d = res_fmt;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        stall_o        = valid_i && !flush_i && (state_q != DONE);
        busy_o         = (state_q != IDLE);
        result_valid_o = (state_q == DONE);
        result_o       = result_q;
    end

endmodule

// File: tb/tb_core_ex_muldiv.sv
// Directed bench for core_ex_muldiv: latency, stall timing, results, flush, reset.
module tb_core_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic        flush_i;
    logic [2:0]  funct3_i;
    logic        word_i;
    logic [63:0] rs1_data_i;
    logic [63:0] rs2_data_i;
    logic        stall_o;
    logic        busy_o;
    logic        result_valid_o;
    logic [63:0] result_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [63:0] last_res = '0;

    core_ex_muldiv #(.XLEN(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_i        (valid_i),
        .flush_i        (flush_i),
        .funct3_i       (funct3_i),
        .word_i         (word_i),
        .rs1_data_i     (rs1_data_i),
        .rs2_data_i     (rs2_data_i),
        .stall_o        (stall_o),
        .busy_o         (busy_o),
        .result_valid_o (result_valid_o),
        .result_o       (result_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
        end
    endtask

    // Issue one op, scramble operands once CALC has begun, measure EX occupancy.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input int unsigned exp_lat);
        int unsigned cyc;
        int unsigned stalls;
        @(posedge clk); #1;
        valid_i = 1'b1; funct3_i = f3; word_i = w; rs1_data_i = a; rs2_data_i = b;
        @(negedge clk);
        cyc = 1;
        stalls = stall_o ? 1 : 0;
        @(posedge clk); #1;
        rs1_data_i = 64'hDEAD_BEEF_0BAD_F00D;
        rs2_data_i = 64'h1234_5678_9ABC_DEF1;
        do begin
            @(negedge clk);
            cyc++;
            if (stall_o) stalls++;
        end while (!result_valid_o && cyc < 100);
        check_eq({tag, ".lat"}, 64'(cyc), 64'(exp_lat));
        check_eq({tag, ".stall"}, 64'(stalls), 64'(exp_lat - 1));
        check_eq({tag, ".res"}, result_o, exp_res);
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(negedge clk);
        check_eq({tag, ".hold"}, {busy_o, result_valid_o, result_o}, {1'b0, 1'b0, exp_res});
        last_res = exp_res;
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0; funct3_i = '0; word_i = 1'b0;
        rs1_data_i = '0; rs2_data_i = '0;
        #12;
        check_eq("rst", {stall_o, busy_o, result_valid_o, result_o}, '0);
        @(negedge clk); rst_n = 1'b1;

        run_op("mul",     3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66);
        run_op("mulhu",   3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        run_op("mulh",    3'b001, 1'b0, '1, '1, 64'h0, 66);
        run_op("mulhsu",  3'b010, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("div0",    3'b100, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("rem0",    3'b110, 1'b0, 64'd100, 64'd0, 64'd100, 66);
        run_op("divovf",  3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 66);
        run_op("removf",  3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h0, 66);
        run_op("divw",    3'b100, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);
        run_op("remw",    3'b110, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34);
        run_op("divuw",   3'b101, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'h0000_0000_7FFF_FFFC, 34);
        run_op("mulw",    3'b000, 1'b1, 64'hAAAA_AAAA_0001_0000, 64'h5555_5555_0000_8000, 64'hFFFF_FFFF_8000_0000, 34);
        run_op("mulhw",   3'b001, 1'b1, 64'h0000_0000_0000_0006, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFD6, 34);
        run_op("remuw0",  3'b111, 1'b1, 64'h0000_0000_8000_0005, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0005, 34);
        run_op("div",     3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 66);

        // Flush at CALC iteration 10
        @(posedge clk); #1;
        valid_i = 1'b1; funct3_i = 3'b000; word_i = 1'b0;
        rs1_data_i = 64'd11; rs2_data_i = 64'd13;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        #1;
        check_eq("flush.stall", {stall_o, busy_o}, {1'b0, 1'b1});
        @(posedge clk); #1;
        check_eq("flush.idle", {busy_o, result_valid_o, result_o}, {1'b0, 1'b0, last_res});
        flush_i = 1'b0; valid_i = 1'b0;
        seen = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (result_valid_o) seen = 1'b1;
        end
        check_eq("flush.novalid", {63'b0, seen}, 64'd0);
        run_op("mul35", 3'b000, 1'b0, 64'd3, 64'd5, 64'd15, 66);

        // Asynchronous reset during CALC
        @(posedge clk); #1;
        valid_i = 1'b1; funct3_i = 3'b101; word_i = 1'b0;
        rs1_data_i = 64'd1000; rs2_data_i = 64'd9;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; valid_i = 1'b0;
        #1;
        check_eq("arst", {stall_o, busy_o, result_valid_o, result_o}, '0);
        @(negedge clk); rst_n = 1'b1;
        run_op("divu", 3'b101, 1'b0, 64'd10, 64'd3, 64'd3, 66);
        run_op("remu", 3'b111, 1'b0, 64'd10, 64'd3, 64'd1, 66);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
